fft_frame_sched: RTL and testbench

FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

---
 rtl/fft_frame_sched.sv | 103 ++++++++++
 tb/tb_fft_frame_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Frame scheduler feeding a show-ahead FIFO into a streaming FFT sink with framing and frame counting.
// Optional macro FFT_FRAME_HOLD_EN: wait for the FFT source end-of-packet before starting the next frame.
module fft_frame_sched #(
    parameter int FFT_LEN = 128,
    parameter int RST_CYC = 16
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        run,
    input  logic        fifo_rd_empty,
    output logic        fifo_rdreq,
    input  logic        fft_ready,
    input  logic        fft_src_eop,
    output logic        fft_rst_n,
    output logic        fft_valid,
    output logic        fft_sop,
    output logic        fft_eop,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int PW = $clog2(FFT_LEN);
    localparam int RW = $clog2(RST_CYC + 1);
    localparam logic [PW-1:0] PT_LAST  = PW'(FFT_LEN - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

    typedef enum logic [1:0] {
        RST_FFT,
        WAIT_RDY,
        STREAM,
        HOLD
    } state_t;

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [PW-1:0] pt_cnt;

`ifndef FFT_FRAME_HOLD_EN
    logic unused_src_eop;
    assign unused_src_eop = fft_src_eop;
`endif

    // A beat moves only when the FIFO has data and the FFT sink accepts it.
    assign fft_valid  = (state == STREAM) & ~fifo_rd_empty & fft_ready;
    assign fifo_rdreq = fft_valid;
    assign fft_sop    = fft_valid & (pt_cnt == '0);
    assign fft_eop    = fft_valid & (pt_cnt == PT_LAST);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= RST_FFT;
            rst_cnt    <= '0;
            pt_cnt     <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            fft_rst_n  <= 1'b0;
        end else begin
            frame_done <= fft_eop;
            if (fft_valid) begin
                pt_cnt <= pt_cnt + 1'b1;
            end
            if (fft_eop) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            case (state)
                RST_FFT: begin
                    if (rst_cnt == RST_LAST) begin
                        fft_rst_n <= 1'b1;
                        state     <= WAIT_RDY;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (fft_ready && run) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    // A frame is never cut short; run is only consulted at its last beat.
                    if (fft_eop) begin
`ifdef FFT_FRAME_HOLD_EN
                        state <= HOLD;
`else
                        state <= run ? STREAM : WAIT_RDY;
`endif
                    end
                end
                HOLD: begin
`ifdef FFT_FRAME_HOLD_EN
                    if (fft_src_eop) begin
                        state <= run ? STREAM : WAIT_RDY;
                    end
`else
                    state <= WAIT_RDY;
`endif
                end
                default: state <= RST_FFT;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized self-checking bench for fft_frame_sched against a beat/frame-level reference model.
// Honours FFT_FRAME_HOLD_EN in the model when the macro is defined for the build.
module tb_fft_frame_sched;

    localparam int FFT_LEN = 128;
    localparam int RST_CYC = 16;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        run;
    logic        fifo_rd_empty;
    logic        fifo_rdreq;
    logic        fft_ready;
    logic        fft_src_eop;
    logic        fft_rst_n;
    logic        fft_valid;
    logic        fft_sop;
    logic        fft_eop;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;

    // Reference model: remaining reset cycles, whether frames may flow, beats delivered in current frame.
    int m_rst_left;
    int m_beats;
    int m_frames;
    bit m_stream;
    bit m_hold;
    bit m_done;

    fft_frame_sched #(
        .FFT_LEN(FFT_LEN),
        .RST_CYC(RST_CYC)
    ) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .run          (run),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rdreq   (fifo_rdreq),
        .fft_ready    (fft_ready),
        .fft_src_eop  (fft_src_eop),
        .fft_rst_n    (fft_rst_n),
        .fft_valid    (fft_valid),
        .fft_sop      (fft_sop),
        .fft_eop      (fft_eop),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic model_reset();
        m_rst_left = RST_CYC;
        m_beats    = 0;
        m_frames   = 0;
        m_stream   = 1'b0;
        m_hold     = 1'b0;
        m_done     = 1'b0;
    endtask

    function automatic bit exp_valid();
        return m_stream && !fifo_rd_empty && fft_ready;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        bit ev;
        ev = exp_valid();
        if (!rst && !fft_rst_n) low_cnt++;
        checkOutput("fft_valid",  {15'd0, fft_valid},  {15'd0, ev});
        checkOutput("fifo_rdreq", {15'd0, fifo_rdreq}, {15'd0, ev});
        checkOutput("fft_sop",    {15'd0, fft_sop},    {15'd0, ev && (m_beats == 0)});
        checkOutput("fft_eop",    {15'd0, fft_eop},    {15'd0, ev && (m_beats == FFT_LEN - 1)});
        checkOutput("frame_done", {15'd0, frame_done}, {15'd0, m_done});
        checkOutput("frame_cnt",  frame_cnt,           16'(m_frames));
        checkOutput("fft_rst_n",  {15'd0, fft_rst_n},  {15'd0, m_rst_left == 0});
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_update();
        bit ev;
        bit eop;
        ev  = exp_valid();
        eop = ev && (m_beats == FFT_LEN - 1);
        if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (m_hold) begin
            if (fft_src_eop) begin
                m_hold   = 1'b0;
                m_stream = run;
            end
        end else if (!m_stream) begin
            if (fft_ready && run) m_stream = 1'b1;
        end else if (ev) begin
            m_beats = (m_beats + 1) % FFT_LEN;
            if (eop) begin
                m_frames = (m_frames + 1) % 65536;
`ifdef FFT_FRAME_HOLD_EN
                m_hold   = 1'b1;
                m_stream = 1'b0;
`else
                m_stream = run;
`endif
            end
        end
        m_done = eop;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rd, input logic se);
        run           = r;
        fifo_rd_empty = e;
        fft_ready     = rd;
        fft_src_eop   = se;
        #1;
        checkAll();
        model_update();
        @(negedge clk_50m);
    endtask

    initial begin
        logic r;
        bit   found;
        rst           = 1'b1;
        run           = 1'b0;
        fifo_rd_empty = 1'b0;
        fft_ready     = 1'b0;
        fft_src_eop   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_50m);
        #1;
        checkAll();
        @(negedge clk_50m);

        // Reset release: fft_rst_n must stay low for exactly RST_CYC cycles.
        rst = 1'b0;
        for (int i = 0; i < RST_CYC + 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom % 2));
        checkOutput("rst_low_cycles", 16'(low_cnt), 16'(RST_CYC));

        // Continuous back-to-back frames.
        for (int i = 0; i < 3 * FFT_LEN + 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'($urandom % 16 == 0));

        // Random FIFO-empty and sink-not-ready stalls.
        for (int i = 0; i < 700; i++)
            applyStimulus(1'b1, 1'($urandom % 4 == 0), 1'($urandom % 5 != 0), 1'($urandom % 16 == 0));

        // Run toggling in segments so frames park and restart.
        r = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            if (i % 60 == 0) r = 1'($urandom % 2);
            applyStimulus(r, 1'($urandom % 6 == 0), 1'($urandom % 6 != 0), 1'($urandom % 16 == 0));
        end

        // Reach beat 64 of a frame, then reset asynchronously in mid-cycle.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (m_stream && m_beats == 64) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("reach_beat64", {15'd0, found}, 16'd1);
        run           = 1'b1;
        fifo_rd_empty = 1'b0;
        fft_ready     = 1'b1;
        fft_src_eop   = 1'b0;
        #1;
        checkAll();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        checkAll();
        @(negedge clk_50m);
        #1;
        checkAll();
        @(negedge clk_50m);
        rst     = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < RST_CYC + 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_low_cycles_mid", 16'(low_cnt), 16'(RST_CYC));
        for (int i = 0; i < 2 * FFT_LEN + 20; i++)
            applyStimulus(1'b1, 1'($urandom % 8 == 0), 1'b1, 1'($urandom % 16 == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
